fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-deep × 8-bit synchronous FIFO. It pops one byte at a time from the FIFO read port and transmits each byte as an 8N1 UART frame on `txd`: one start bit, eight data bits LSB first, one stop bit, with a parameterised bit period. It is the FIFO's only reader, and it owns the FIFO's `r_en` timing.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_uart_tx_baud_gen.sv | 31 +++
 rtl/fifo_uart_tx.sv | 110 +++++++++++
 tb/tb_fifo_uart_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8x8 synchronous FIFO and its UART drain stage.
package fifo_pkg;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, restarted by clear.
module baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else if (clear || r_cnt == LAST_CNT)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign tick     = (r_cnt == LAST_CNT);
   // One cycle early so the caller can register a last-cycle strobe.
   assign pre_tick = (r_cnt == PRE_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as an 8N1 UART frame.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = fifo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              tx_en,
   output logic              fifo_rd_en,
   output logic              txd,
   output logic              busy,
   output logic              frame_done
);

   import fifo_pkg::*;

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   tx_state_t         r_state;
   logic [DATA_W-1:0] r_shreg;
   logic [2:0]        r_bitcnt;
   logic              r_txd;
   logic              r_rd_en;
   logic              r_frame_done;
   logic              w_tick;
   logic              w_pre_tick;
   logic              w_clear;

   // Baud counter restarts on the same edge that enters START.
   assign w_clear = (r_state == LOAD);

   baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_clear),
      .tick    (w_tick),
      .pre_tick(w_pre_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_shreg      <= '0;
         r_bitcnt     <= '0;
         r_txd        <= 1'b1;
         r_rd_en      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_rd_en      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (tx_en && !fifo_empty) begin
                  r_state <= POP;
                  r_rd_en <= 1'b1;
               end
            end
            POP: r_state <= LOAD;
            LOAD: begin
               r_shreg  <= fifo_dout;
               r_bitcnt <= '0;
               r_txd    <= 1'b0;
               r_state  <= START;
            end
            START: begin
               if (w_tick) begin
                  r_txd   <= r_shreg[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_shreg <= r_shreg >> 1;
                  if (r_bitcnt == LAST_BIT) begin
                     r_bitcnt <= '0;
                     r_txd    <= 1'b1;
                     r_state  <= STOP;
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                     r_txd    <= r_shreg[1];
                  end
               end
            end
            STOP: begin
               if (w_pre_tick)
                  r_frame_done <= 1'b1;
               if (w_tick) begin
                  if (tx_en && !fifo_empty) begin
                     r_state <= POP;
                     r_rd_en <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign txd        = r_txd;
   assign fifo_rd_en = r_rd_en;
   assign frame_done = r_frame_done;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed and random-byte checks of fifo_uart_tx against a line-level UART model.
module tb_fifo_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk        = 1'b0;
   logic       rst        = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       tx_en      = 1'b0;
   logic [7:0] fifo_dout  = '0;
   logic       fifo_rd_en;
   logic       txd;
   logic       busy;
   logic       frame_done;

   int n_assert    = 0;
   int n_fail      = 0;
   int n_pops      = 0;
   int n_done      = 0;
   int n_pushed    = 0;
   int n_underflow = 0;

   logic [7:0] q[$];

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .tx_en     (tx_en),
      .fifo_rd_en(fifo_rd_en),
      .txd       (txd),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: read data valid the cycle after rd_en, registered empty flag.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (q.size() == 0) n_underflow++;
         else fifo_dout <= q.pop_front();
      end
      fifo_empty <= (q.size() == 0);
   end

   always @(negedge clk) begin
      if (fifo_rd_en) n_pops++;
      if (frame_done) n_done++;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      n_pushed++;
   endtask

   task automatic wait_start(output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (txd !== 1'b0 && waited < 200);
   endtask

   // Waits for the start bit, then checks every line cycle of one frame.
   // drop_at >= 0 deasserts tx_en at that cycle of the frame.
   task automatic check_frame(input logic [7:0] b, input int exp_wait, input int drop_at);
      int   w;
      int   bit_idx;
      logic ebit;
      wait_start(w);
      chkn("start_latency", w, exp_wait);
      if (txd !== 1'b0) return;
      for (int c = 0; c < FRAME; c++) begin
         if (c > 0) @(negedge clk);
         if (c == drop_at) tx_en = 1'b0;
         bit_idx = c / CPB;
         if (bit_idx == 0) ebit = 1'b0;
         else if (bit_idx == 9) ebit = 1'b1;
         else ebit = b[bit_idx-1];
         chk1("txd_bit", txd, ebit);
         chk1("frame_done", frame_done, (c == FRAME - 1));
         chk1("busy_in_frame", busy, 1'b1);
      end
   endtask

   initial begin
      int         p0;
      int         w;
      logic [7:0] rb;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] rnd[6];

      // Reset with a byte already queued and tx_en high.
      push(8'hA5);
      tx_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk1("rst_txd", txd, 1'b1);
         chk1("rst_rd_en", fifo_rd_en, 1'b0);
         chk1("rst_busy", busy, 1'b0);
      end
      rst = 1'b1;

      // Single byte; empty already low at release, so start is 3 edges later.
      check_frame(8'hA5, 3, -1);
      @(negedge clk);
      chk1("single_idle_busy", busy, 1'b0);
      chkn("single_pops", n_pops, 1);
      chkn("single_done", n_done, 1);

      // Back-to-back: push at a negedge adds one cycle for the registered empty flag.
      p0 = n_pops;
      push(8'h00);
      push(8'hFF);
      check_frame(8'h00, 4, -1);
      check_frame(8'hFF, 3, -1);
      @(negedge clk);
      chk1("b2b_idle_busy", busy, 1'b0);
      chk1("b2b_empty", fifo_empty, 1'b1);
      chkn("b2b_pops", n_pops - p0, 2);

      // Flow control: tx_en dropped during DATA of 0x3C with two bytes behind it.
      p0 = n_pops;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      push(8'h3C);
      push(b1);
      push(b2);
      check_frame(8'h3C, 4, 16);
      repeat (20) begin
         @(negedge clk);
         chk1("hold_txd", txd, 1'b1);
         chk1("hold_rd_en", fifo_rd_en, 1'b0);
      end
      chk1("hold_busy", busy, 1'b0);
      chkn("hold_pops", n_pops - p0, 1);
      tx_en = 1'b1;
      check_frame(b1, 3, -1);
      check_frame(b2, 3, -1);
      chkn("flow_pops", n_pops - p0, 3);

      // Random bytes streamed back-to-back.
      p0 = n_pops;
      for (int i = 0; i < 6; i++) begin
         rnd[i] = 8'($urandom);
         push(rnd[i]);
      end
      for (int i = 0; i < 6; i++) check_frame(rnd[i], (i == 0) ? 4 : 3, -1);
      chkn("rand_pops", n_pops - p0, 6);

      // Reset during DATA of 0x81; the popped byte is dropped.
      push(8'h81);
      wait_start(w);
      chkn("rstmid_start_latency", w, 4);
      repeat (12) @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("rstmid_txd", txd, 1'b1);
      chk1("rstmid_busy", busy, 1'b0);
      chk1("rstmid_done", frame_done, 1'b0);
      chk1("rstmid_rd_en", fifo_rd_en, 1'b0);
      rb = 8'($urandom);
      push(rb);
      repeat (2) begin
         @(negedge clk);
         chk1("rstmid_hold_txd", txd, 1'b1);
         chk1("rstmid_hold_busy", busy, 1'b0);
      end
      rst = 1'b1;
      check_frame(rb, 3, -1);

      // Empty FIFO: nothing may move.
      repeat (100) begin
         @(negedge clk);
         chk1("empty_txd", txd, 1'b1);
         chk1("empty_rd_en", fifo_rd_en, 1'b0);
      end
      chkn("no_underflow", n_underflow, 0);
      chkn("all_popped", n_pops, n_pushed);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
